// File: rtl/fc_layer_sequencer_pkg.sv
// fc_pkg: shared state encoding, neuron address width and weight address helper.
package fc_pkg;
  localparam int NRN_ADDR_W = 3;
  typedef enum logic [3:0] {IDLE, CLEAR, ISSUE, FEED, DRAIN, FINAL, SETTLE, WRITE, DONE} fc_seq_state_t;
  function automatic int wt_base(input int group, input int chunks);
    return group * chunks;
  endfunction
endpackage

// File: rtl/fc_layer_sequencer_if.sv
// fc_layer_sequencer_if: buffer read, neuron bank and result handshake signals of the sequencer.
interface fc_layer_sequencer_if #(
  parameter int FADDR_W = 3,
  parameter int WADDR_W = 6,
  parameter int GRP_W = 2
);
  import fc_pkg::*;
  logic feat_rd_en;
  logic [FADDR_W-1:0] feat_rd_addr;
  logic wt_rd_en;
  logic [WADDR_W-1:0] wt_rd_addr;
  logic nrn_rst_n;
  logic nrn_en;
  logic [NRN_ADDR_W-1:0] nrn_addr;
  logic nrn_full_data;
  logic res_valid;
  logic [GRP_W-1:0] res_group;
  logic res_ready;
  modport master (
    output feat_rd_en, feat_rd_addr, wt_rd_en, wt_rd_addr, nrn_rst_n, nrn_en, nrn_addr,
    output nrn_full_data, res_valid, res_group,
    input res_ready
  );
  modport slave (
    input feat_rd_en, feat_rd_addr, wt_rd_en, wt_rd_addr, nrn_rst_n, nrn_en, nrn_addr,
    input nrn_full_data, res_valid, res_group,
    output res_ready
  );
endinterface

// File: rtl/fc_layer_sequencer_counter.sv
// fc_seq_counter: clearable up-counter exposing its next value and a terminal-count flag.
module fc_seq_counter #(
  parameter int W = 3,
  parameter int MAX = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic [W-1:0] count_n,
  output logic last
);
  logic [W-1:0] count;
  assign count_n = clr ? '0 : inc ? count + 1'b1 : count;
  assign last = count == W'(MAX - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) count <= '0;
    else count <= count_n;
endmodule

// File: rtl/fc_layer_sequencer.sv
// fc_layer_sequencer: steps each neuron group through clear, chunked feed, drain, final and result write.
module fc_layer_sequencer
  import fc_pkg::*;
#(
  parameter int NUM_CHUNKS = 7,
  parameter int NUM_GROUPS = 4,
  parameter int PU_LAT = 2,
  parameter int FADDR_W = 3,
  parameter int WADDR_W = 6,
  parameter int GRP_W = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  output logic busy,
  output logic done,
  fc_layer_sequencer_if.master bus
);
  localparam int DW = $clog2(PU_LAT + 2);
  if (NUM_CHUNKS < 1 || NUM_CHUNKS > 8) begin : g_chk_chunks
    $error("NUM_CHUNKS must be within 1..8");
  end
  if ((1 << WADDR_W) < NUM_GROUPS * NUM_CHUNKS) begin : g_chk_waddr
    $error("WADDR_W too narrow for NUM_GROUPS*NUM_CHUNKS");
  end
  fc_seq_state_t state, state_n;
  logic [DW-1:0] drain, drain_n;
  logic chunk_clr, chunk_inc, chunk_last, grp_clr, grp_inc, grp_last;
  logic [NRN_ADDR_W-1:0] chunk_n;
  logic [GRP_W-1:0] grp_n;
  fc_seq_counter #(.W(NRN_ADDR_W), .MAX(NUM_CHUNKS)) u_chunk (
    .clk(clk), .reset(reset), .clr(chunk_clr), .inc(chunk_inc), .count_n(chunk_n), .last(chunk_last)
  );
  fc_seq_counter #(.W(GRP_W), .MAX(NUM_GROUPS)) u_group (
    .clk(clk), .reset(reset), .clr(grp_clr), .inc(grp_inc), .count_n(grp_n), .last(grp_last)
  );
  always_comb begin
    state_n = state;
    drain_n = drain;
    chunk_clr = 1'b0;
    chunk_inc = 1'b0;
    grp_clr = 1'b0;
    grp_inc = 1'b0;
    case (state)
      IDLE: begin
        grp_clr = start;
        state_n = start ? CLEAR : IDLE;
      end
      CLEAR: begin
        chunk_clr = 1'b1;
        state_n = ISSUE;
      end
      ISSUE: state_n = FEED;
      FEED: begin
        chunk_inc = !chunk_last;
        drain_n = '0;
        state_n = !chunk_last ? ISSUE : PU_LAT == 0 ? FINAL : DRAIN;
      end
      DRAIN: begin
        drain_n = drain + 1'b1;
        state_n = drain == DW'(PU_LAT - 1) ? FINAL : DRAIN;
      end
      FINAL: state_n = SETTLE;
      SETTLE: state_n = WRITE;
      WRITE: begin
        grp_inc = bus.res_ready && !grp_last;
        state_n = !bus.res_ready ? WRITE : grp_last ? DONE : CLEAR;
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // Outputs are decoded from the next state so each one is a flop aligned with its state.
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      drain <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      bus.feat_rd_en <= 1'b0;
      bus.feat_rd_addr <= '0;
      bus.wt_rd_en <= 1'b0;
      bus.wt_rd_addr <= '0;
      bus.nrn_rst_n <= 1'b0;
      bus.nrn_en <= 1'b0;
      bus.nrn_addr <= '0;
      bus.nrn_full_data <= 1'b0;
      bus.res_valid <= 1'b0;
      bus.res_group <= '0;
    end else begin
      state <= state_n;
      drain <= drain_n;
      busy <= state_n != IDLE && state_n != DONE;
      done <= state_n == DONE;
      bus.feat_rd_en <= state_n == ISSUE;
      bus.feat_rd_addr <= FADDR_W'(chunk_n);
      bus.wt_rd_en <= state_n == ISSUE;
      bus.wt_rd_addr <= WADDR_W'(wt_base(int'(grp_n), NUM_CHUNKS) + int'(chunk_n));
      bus.nrn_rst_n <= state_n != CLEAR;
      bus.nrn_en <= state_n == FEED;
      bus.nrn_addr <= chunk_n;
      bus.nrn_full_data <= state_n == FINAL;
      bus.res_valid <= state_n == WRITE;
      bus.res_group <= grp_n;
    end
endmodule

// File: tb/tb_fc_layer_sequencer.sv
// tb_fc_layer_sequencer: scenario tasks with a result scoreboard for the default and minimal configurations.
module tb_fc_layer_sequencer;
  typedef struct {int grp; int at;} exp_t;
  logic clk, reset, start_a, start_b, busy_a, done_a, busy_b, done_b;
  int cyc = 0, t0 = 0, total = 0, bad = 0;
  exp_t sb[$];
  fc_layer_sequencer_if #(.FADDR_W(3), .WADDR_W(6), .GRP_W(2)) ifa ();
  fc_layer_sequencer_if #(.FADDR_W(3), .WADDR_W(6), .GRP_W(1)) ifb ();
  fc_layer_sequencer dut_a (
    .clk(clk), .reset(reset), .start(start_a), .busy(busy_a), .done(done_a), .bus(ifa.master)
  );
  fc_layer_sequencer #(.NUM_CHUNKS(1), .NUM_GROUPS(1), .PU_LAT(0), .FADDR_W(3), .WADDR_W(6), .GRP_W(1)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .busy(busy_b), .done(done_b), .bus(ifb.master)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk)
    if (reset && ifa.res_valid && ifa.res_ready) begin
      total++;
      if (sb.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: result group=%0d at offset %0d, none expected", ifa.res_group, cyc - t0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (ifa.res_group !== 2'(e.grp) || cyc - t0 !== e.at) begin
          bad++;
          $display("FAIL sb_result: got group=%0d offset=%0d, want group=%0d offset=%0d", ifa.res_group, cyc - t0, e.grp, e.at);
        end
      end
    end
  always @(negedge clk)
    if (ifa.nrn_en) begin
      total++;
      if (ifa.nrn_full_data || !ifa.nrn_rst_n) begin
        bad++;
        $display("FAIL mutex: nrn_en with full_data=%b rst_n=%b, want 0 and 1", ifa.nrn_full_data, ifa.nrn_rst_n);
      end
    end
  task automatic launch_a;
    @(posedge clk); #1;
    start_a = 1'b1;
    t0 = cyc;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask
  task automatic push_pass(input int stall);
    for (int g = 0; g < 4; g++) sb.push_back('{g, 20 + 20 * g + stall});
  endtask
  task automatic wait_done(input int want, input string name);
    int n = 1;
    while (!done_a && n < 300) begin
      @(posedge clk); #1;
      n = cyc - t0;
    end
    total++;
    if (n !== want || done_a !== 1'b1 || busy_a !== 1'b0) begin
      bad++;
      $display("FAIL %s: done=%b busy=%b at offset %0d, want done=1 busy=0 at %0d", name, done_a, busy_a, n, want);
    end
  endtask
  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({busy_a, done_a, ifa.feat_rd_en, ifa.wt_rd_en, ifa.nrn_en, ifa.nrn_full_data, ifa.res_valid, ifa.nrn_rst_n} !== 8'b0) begin
      bad++;
      $display("FAIL reset_strobes: got %b, want 00000000",
               {busy_a, done_a, ifa.feat_rd_en, ifa.wt_rd_en, ifa.nrn_en, ifa.nrn_full_data, ifa.res_valid, ifa.nrn_rst_n});
    end
    total++;
    if ({ifa.feat_rd_addr, ifa.wt_rd_addr, ifa.nrn_addr, ifa.res_group} !== 14'b0) begin
      bad++;
      $display("FAIL reset_addrs: got %h, want 0", {ifa.feat_rd_addr, ifa.wt_rd_addr, ifa.nrn_addr, ifa.res_group});
    end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (ifa.nrn_rst_n !== 1'b1 || busy_a !== 1'b0) begin
      bad++;
      $display("FAIL idle_after_reset: nrn_rst_n=%b busy=%b, want 1 0", ifa.nrn_rst_n, busy_a);
    end
  endtask
  task automatic test_full_pass;
    int n = 1;
    ifa.res_ready = 1'b1;
    push_pass(0);
    launch_a();
    total++;
    if (busy_a !== 1'b1 || ifa.nrn_rst_n !== 1'b0) begin
      bad++;
      $display("FAIL first_clear: busy=%b nrn_rst_n=%b, want 1 0", busy_a, ifa.nrn_rst_n);
    end
    wait_done(81, "done_cycle");
    @(posedge clk); #1;
    total++;
    if (done_a !== 1'b0 || sb.size() != 0) begin
      bad++;
      $display("FAIL pass_end: done=%b pending=%0d, want 0 0", done_a, sb.size());
    end
  endtask
  task automatic test_group2_addr;
    int n = 1, idx = 0, pc = 0;
    logic prev = 1'b0;
    push_pass(0);
    launch_a();
    while (!done_a && n < 300) begin
      @(posedge clk); #1;
      n = cyc - t0;
      if (prev) begin
        total++;
        if (ifa.nrn_en !== 1'b1 || ifa.nrn_addr !== 3'(pc)) begin
          bad++;
          $display("FAIL nrn_addr: en=%b addr=%0d, want 1 %0d", ifa.nrn_en, ifa.nrn_addr, pc);
        end
      end
      prev = ifa.wt_rd_en;
      if (ifa.wt_rd_en) begin
        total++;
        if (ifa.wt_rd_addr !== 6'(idx) || ifa.feat_rd_addr !== 3'(idx % 7) || ifa.feat_rd_en !== 1'b1) begin
          bad++;
          $display("FAIL rd_addr: wt=%0d feat=%0d fen=%b, want %0d %0d 1", ifa.wt_rd_addr, ifa.feat_rd_addr, ifa.feat_rd_en, idx, idx % 7);
        end
        pc = idx % 7;
        idx++;
      end
    end
    total++;
    if (idx !== 28 || !done_a) begin
      bad++;
      $display("FAIL read_count: got %0d reads done=%b, want 28 1", idx, done_a);
    end
  endtask
  task automatic test_backpressure;
    int n = 1;
    repeat (2) @(posedge clk);
    ifa.res_ready = 1'b0;
    push_pass(5);
    launch_a();
    while (!done_a && n < 300) begin
      @(posedge clk); #1;
      n = cyc - t0;
      if (n >= 20 && n <= 24) begin
        total++;
        if (ifa.res_valid !== 1'b1 || ifa.res_group !== 2'd0) begin
          bad++;
          $display("FAIL stall_hold: valid=%b group=%0d at %0d, want 1 0", ifa.res_valid, ifa.res_group, n);
        end
      end
      if (n == 25) ifa.res_ready = 1'b1;
      if (n == 26) begin
        total++;
        if (ifa.nrn_rst_n !== 1'b0 || ifa.res_valid !== 1'b0) begin
          bad++;
          $display("FAIL clear_after_accept: rst_n=%b valid=%b, want 0 0", ifa.nrn_rst_n, ifa.res_valid);
        end
      end
    end
    total++;
    if (n !== 86) begin
      bad++;
      $display("FAIL stall_done: done at offset %0d, want 86", n);
    end
  endtask
  task automatic test_start_ignored;
    int n = 1;
    repeat (2) @(posedge clk);
    push_pass(0);
    launch_a();
    while (!done_a && n < 300) begin
      @(posedge clk); #1;
      n = cyc - t0;
      start_a = n == 30;
    end
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (busy_a !== 1'b0 || ifa.nrn_rst_n !== 1'b1 || sb.size() != 0) begin
      bad++;
      $display("FAIL start_ignored: busy=%b rst_n=%b pending=%0d, want 0 1 0", busy_a, ifa.nrn_rst_n, sb.size());
    end
    push_pass(0);
    launch_a();
    wait_done(81, "fresh_pass");
  endtask
  task automatic test_reset_mid;
    int n = 1;
    logic seen = 1'b0;
    repeat (2) @(posedge clk);
    sb.push_back('{0, 20});
    launch_a();
    while (n < 29) begin
      @(posedge clk); #1;
      n = cyc - t0;
    end
    total++;
    if (ifa.nrn_en !== 1'b1 || ifa.nrn_addr !== 3'd3 || ifa.wt_rd_addr !== 6'd10) begin
      bad++;
      $display("FAIL mid_feed: en=%b addr=%0d wt=%0d, want 1 3 10", ifa.nrn_en, ifa.nrn_addr, ifa.wt_rd_addr);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({busy_a, ifa.nrn_en, ifa.feat_rd_en, ifa.wt_rd_en, ifa.nrn_full_data, ifa.res_valid, ifa.nrn_rst_n} !== 7'b0) begin
      bad++;
      $display("FAIL async_reset: got %b, want 0000000",
               {busy_a, ifa.nrn_en, ifa.feat_rd_en, ifa.wt_rd_en, ifa.nrn_full_data, ifa.res_valid, ifa.nrn_rst_n});
    end
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      seen |= done_a | busy_a;
    end
    total++;
    if (seen !== 1'b0 || sb.size() != 0 || ifa.nrn_rst_n !== 1'b1) begin
      bad++;
      $display("FAIL after_abort: done_or_busy=%b pending=%0d rst_n=%b, want 0 0 1", seen, sb.size(), ifa.nrn_rst_n);
    end
  endtask
  task automatic test_small;
    logic [5:0] tab [8];
    logic [5:0] got;
    int tb0;
    tab = '{6'b100000, 6'b010000, 6'b001000, 6'b000100, 6'b000000, 6'b000010, 6'b000001, 6'b000000};
    ifb.res_ready = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b1;
    tb0 = cyc;
    for (int n = 1; n <= 8; n++) begin
      @(posedge clk); #1;
      start_b = 1'b0;
      got = {!ifb.nrn_rst_n, ifb.feat_rd_en, ifb.nrn_en, ifb.nrn_full_data, ifb.res_valid, done_b};
      total++;
      if (got !== tab[n-1] || cyc - tb0 !== n) begin
        bad++;
        $display("FAIL small_seq: cycle %0d got %b, want %b", n, got, tab[n-1]);
      end
    end
    total++;
    if (busy_b !== 1'b0 || ifb.res_group !== 1'b0 || ifb.wt_rd_addr !== 6'd0) begin
      bad++;
      $display("FAIL small_end: busy=%b group=%0d wt=%0d, want 0 0 0", busy_b, ifb.res_group, ifb.wt_rd_addr);
    end
  endtask
  initial begin
    start_a = 1'b0;
    start_b = 1'b0;
    ifa.res_ready = 1'b1;
    ifb.res_ready = 1'b1;
    test_reset();
    test_full_pass();
    test_group2_addr();
    test_backpressure();
    test_start_ignored();
    test_reset_mid();
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
